// File: rtl/branch_pkg.sv
// Shared types and constants for the branch sequencing controller:
// FSM states, 2-bit counter encodings, branch funct3 codes.
package branch_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    REDIRECT = 2'b01,
    FLUSH    = 2'b10
  } state_t;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  // Saturating 2-bit counter step
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == ST) ? ST : ctr + 2'd1;
    else       return (ctr == SNT) ? SNT : ctr - 2'd1;
  endfunction

  function automatic logic is_cond_branch(input logic [2:0] funct3);
    return funct3 inside {BEQ, BNE, BLT, BGE, BLTU, BGEU};
  endfunction

endpackage

// File: rtl/bht.sv
// Branch history table: array of 2-bit saturating counters, reset to
// weakly not-taken, with a combinational read port and one update port.
module bht
  import branch_pkg::*;
#(
  parameter  int unsigned ENTRIES = 16,
  localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  logic [1:0] ctr [ENTRIES];

  // Read returns the pre-update value on a same-index collision
  assign rd_ctr = ctr[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) ctr[i] <= WNT;
    end else if (upd_en) begin
      ctr[upd_idx] <= ctr_next(ctr[upd_idx], upd_taken);
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// Branch sequencing controller: resolves MEM-stage branches, redirects fetch
// on mispredict and squashes younger stages. BHT built only with BRANCH_PREDICT_EN.
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned BHT_ENTRIES  = 16,
  parameter int unsigned FLUSH_CYCLES = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  input  logic            mem_valid,
  input  logic            mem_is_branch,
  input  logic [XLEN-1:0] mem_pc,
  input  logic [XLEN-1:0] mem_target,
  input  logic            mem_pred_taken,
  input  logic            resolve,
  input  logic            redirect_ready,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic [15:0]     mispredict_count
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);
  localparam int unsigned CNT_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [XLEN-1:0]   rpc_d;
  logic [15:0]       count_d;
  logic              br_event;
  logic              bht_upd;
  logic              mispred;
  logic [IDX_W-1:0]  if_idx;
  logic [IDX_W-1:0]  mem_idx;

  assign br_event = mem_valid & mem_is_branch;
  assign if_idx   = if_pc[IDX_W+1:2];
  assign mem_idx  = mem_pc[IDX_W+1:2];

`ifdef BRANCH_PREDICT_EN
  logic [1:0] rd_ctr;
  logic       unused_bits;

  bht #(.ENTRIES(BHT_ENTRIES)) u_bht (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (if_idx),
    .rd_ctr    (rd_ctr),
    .upd_en    (bht_upd),
    .upd_idx   (mem_idx),
    .upd_taken (resolve)
  );

  assign pred_taken  = if_valid & rd_ctr[1];
  assign mispred     = resolve ^ mem_pred_taken;
  assign unused_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0], mem_pc[1:0], rd_ctr[0]};
`else
  logic unused_bits;

  // Static not-taken prediction: only taken branches need a redirect
  assign pred_taken  = 1'b0;
  assign mispred     = resolve;
  assign unused_bits = ^{if_valid, if_pc, if_idx, mem_idx, mem_pred_taken, bht_upd};
`endif

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    rpc_d   = redirect_pc;
    count_d = mispredict_count;
    bht_upd = 1'b0;
    case (state)
      IDLE: begin
        if (br_event) begin
          bht_upd = 1'b1;
          if (mispred) begin
            rpc_d   = resolve ? mem_target : mem_pc + XLEN'(4);
            count_d = mispredict_count + 16'd1;
            state_d = REDIRECT;
          end
        end
      end
      REDIRECT: begin
        if (redirect_ready) begin
          if (FLUSH_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            cnt_d   = CNT_W'(FLUSH_CYCLES);
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (cnt <= CNT_W'(1)) state_d = IDLE;
        else                  cnt_d   = cnt - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs registered from the next state so they align with the state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      cnt              <= '0;
      redirect_pc      <= '0;
      mispredict_count <= '0;
      redirect_valid   <= 1'b0;
      flush            <= 1'b0;
    end else begin
      state            <= state_d;
      cnt              <= cnt_d;
      redirect_pc      <= rpc_d;
      mispredict_count <= count_d;
      redirect_valid   <= (state_d == REDIRECT);
      flush            <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl; follows BRANCH_PREDICT_EN to pick
// the predicted or static-not-taken reference behaviour.
module tb_branch_ctrl;

  localparam int unsigned FC = 3;
`ifdef BRANCH_PREDICT_EN
  localparam bit PRED_EN = 1'b1;
`else
  localparam bit PRED_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic        mem_valid;
  logic        mem_is_branch;
  logic [31:0] mem_pc;
  logic [31:0] mem_target;
  logic        mem_pred_taken;
  logic        resolve;
  logic        redirect_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [15:0] mispredict_count;

  branch_ctrl #(.XLEN(32), .BHT_ENTRIES(16), .FLUSH_CYCLES(FC)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .if_valid         (if_valid),
    .if_pc            (if_pc),
    .pred_taken       (pred_taken),
    .mem_valid        (mem_valid),
    .mem_is_branch    (mem_is_branch),
    .mem_pc           (mem_pc),
    .mem_target       (mem_target),
    .mem_pred_taken   (mem_pred_taken),
    .resolve          (resolve),
    .redirect_ready   (redirect_ready),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .flush            (flush),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [1:0]  m_bht[16];
  logic [15:0] m_count;

  function automatic logic m_pred(input logic [31:0] pc);
    return PRED_EN ? m_bht[pc[5:2]][1] : 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_bht[i] = 2'b01;
    m_count = 16'd0;
    exp_q.delete();
  endtask

  // Drives one branch for one cycle; returns at posedge+1 after it was sampled
  task automatic drive_branch(input logic [31:0] pc, input logic [31:0] tgt,
                              input logic pred, input logic res, input bit live,
                              output bit mis);
    mem_valid = 1'b1; mem_is_branch = 1'b1; mem_pc = pc; mem_target = tgt;
    mem_pred_taken = pred; resolve = res; if_valid = 1'b1; if_pc = pc;
    @(negedge clk);
    checks++;
    if (pred_taken !== m_pred(pc)) begin
      failures++;
      $display("FAIL pred_same_cycle pc=%h: got %b expected %b", pc, pred_taken, m_pred(pc));
    end
    mis = 1'b0;
    if (live) begin
      if (PRED_EN) begin
        if (res) m_bht[pc[5:2]] = (m_bht[pc[5:2]] == 2'b11) ? 2'b11 : m_bht[pc[5:2]] + 2'd1;
        else     m_bht[pc[5:2]] = (m_bht[pc[5:2]] == 2'b00) ? 2'b00 : m_bht[pc[5:2]] - 2'd1;
      end
      mis = PRED_EN ? (res != pred) : res;
      if (mis) begin
        exp_q.push_back(res ? tgt : pc + 32'd4);
        m_count = m_count + 16'd1;
      end
    end
    @(posedge clk); #1;
    mem_valid = 1'b0; mem_is_branch = 1'b0; resolve = 1'bx; if_valid = 1'b0;
  endtask

  task automatic check_count(input string name);
    checks++;
    if (mispredict_count !== m_count) begin
      failures++;
      $display("FAIL %s count: got %h expected %h", name, mispredict_count, m_count);
    end
  endtask

  // Stalls redirect_ready, optionally injects a wrong-path branch, then follows the flush
  task automatic handle_redirect(input int stall, input bit younger, input string name);
    logic [31:0] exp_pc;
    bit dm;
    exp_pc = 32'hDEAD_BEEF;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard: got empty queue expected a pending redirect", name);
    end else exp_pc = exp_q.pop_front();
    redirect_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      if (younger && i == 2) begin
        drive_branch(32'h104, 32'h300, 1'b0, 1'b1, 1'b0, dm);
      end else begin
        @(negedge clk);
        checks++;
        if ({redirect_valid, flush, redirect_pc} !== {1'b1, 1'b1, exp_pc}) begin
          failures++;
          $display("FAIL %s stall%0d rv/flush/pc: got %b/%b/%h expected 1/1/%h",
                   name, i, redirect_valid, flush, redirect_pc, exp_pc);
        end
        @(posedge clk); #1;
      end
    end
    redirect_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({redirect_valid, flush, redirect_pc} !== {1'b1, 1'b1, exp_pc}) begin
      failures++;
      $display("FAIL %s handshake rv/flush/pc: got %b/%b/%h expected 1/1/%h",
               name, redirect_valid, flush, redirect_pc, exp_pc);
    end
    @(posedge clk); #1;
    redirect_ready = 1'b0;
    for (int j = 0; j < int'(FC); j++) begin
      @(negedge clk);
      checks++;
      if ({redirect_valid, flush} !== 2'b01) begin
        failures++;
        $display("FAIL %s flush%0d rv/flush: got %b/%b expected 0/1", name, j, redirect_valid, flush);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if ({redirect_valid, flush} !== 2'b00) begin
      failures++;
      $display("FAIL %s idle rv/flush: got %b/%b expected 0/0", name, redirect_valid, flush);
    end
    check_count(name);
    @(posedge clk); #1;
  endtask

  task automatic quiet(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++;
      if ({redirect_valid, flush} !== 2'b00) begin
        failures++;
        $display("FAIL %s quiet%0d rv/flush: got %b/%b expected 0/0", name, i, redirect_valid, flush);
      end
      @(posedge clk); #1;
    end
    check_count(name);
  endtask

  task automatic check_pred(input logic [31:0] pc, input string name);
    if_valid = 1'b1; if_pc = pc;
    @(negedge clk);
    checks++;
    if (pred_taken !== m_pred(pc)) begin
      failures++;
      $display("FAIL %s pred pc=%h: got %b expected %b", name, pc, pred_taken, m_pred(pc));
    end
    @(posedge clk); #1;
    if_valid = 1'b0;
  endtask

  // Resolve with the prediction fed back from the model
  task automatic run_branch(input logic [31:0] pc, input logic [31:0] tgt, input logic res,
                            input string name);
    bit mis;
    drive_branch(pc, tgt, m_pred(pc), res, 1'b1, mis);
    if (mis) handle_redirect(0, 1'b0, name);
    else     quiet(2, name);
  endtask

  task automatic test_reset();
    logic [31:0] pcs [4];
    bit mis;
    pcs[0] = 32'h0; pcs[1] = 32'h40; pcs[2] = 32'h100; pcs[3] = 32'hFFFF_FFFC;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({redirect_valid, flush, redirect_pc, mispredict_count} !== 50'd0) begin
      failures++;
      $display("FAIL reset_init: got %b/%b/%h/%h expected all zero",
               redirect_valid, flush, redirect_pc, mispredict_count);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    drive_branch(32'h100, 32'h200, 1'b0, 1'b1, 1'b1, mis);
    @(negedge clk);
    checks++;
    if (redirect_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_pre_redirect rv: got %b expected 1", redirect_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({redirect_valid, flush, redirect_pc, mispredict_count} !== 50'd0) begin
      failures++;
      $display("FAIL reset_mid_redirect: got %b/%b/%h/%h expected all zero",
               redirect_valid, flush, redirect_pc, mispredict_count);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) check_pred(pcs[i], "reset_pred");
    quiet(2, "reset_idle");
  endtask

  task automatic test_correct_not_taken();
    run_branch(32'h100, 32'h200, 1'b0, "correct_nt");
    check_pred(32'h100, "correct_nt");
  endtask

  task automatic test_taken_mispredict();
    bit mis;
    drive_branch(32'h100, 32'h200, 1'b0, 1'b1, 1'b1, mis);
    handle_redirect(0, 1'b0, "taken_mis");
  endtask

  task automatic test_back_to_back_stall();
    bit mis;
    drive_branch(32'h100, 32'h200, 1'b0, 1'b1, 1'b1, mis);
    handle_redirect(5, 1'b1, "backpressure");
    check_pred(32'h104, "backpressure_idx1");
  endtask

  task automatic test_wrap();
    bit mis;
    drive_branch(32'hFFFF_FFFC, 32'h1000, 1'b1, 1'b0, 1'b1, mis);
    if (mis) handle_redirect(0, 1'b0, "wrap");
    else     quiet(2, "wrap");
  endtask

  task automatic test_saturation();
    @(posedge clk); #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) run_branch(32'h40, 32'h80, 1'b1, "saturation");
    check_pred(32'h40, "saturation");
    checks++;
    if (m_pred(32'h40) !== PRED_EN) begin
      failures++;
      $display("FAIL saturation_model: got %b expected %b", m_pred(32'h40), PRED_EN);
    end
    if_valid = 1'b0; if_pc = 32'h40;
    @(negedge clk);
    checks++;
    if (pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL pred_gated: got %b expected 0", pred_taken);
    end
  endtask

  initial begin
    rst_n = 1'b0; if_valid = 1'b0; if_pc = '0; mem_valid = 1'b0; mem_is_branch = 1'b0;
    mem_pc = '0; mem_target = '0; mem_pred_taken = 1'b0; resolve = 1'b0; redirect_ready = 1'b0;
    model_reset();
    test_reset();
    test_correct_not_taken();
    test_taken_mispredict();
    test_back_to_back_stall();
    test_wrap();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
